// File: rtl/seg_fader.sv
// seg_fader: per-segment afterglow stage for the 7-segment snake generator.
//
// A segment that turns on goes to full brightness at once. A segment that
// turns off fades out one brightness step per decay tick. The brightness is
// driven onto the pad as a PWM pulse that starts at each PWM period wrap.
//
// Optional build macro:
//   SEG_FADER_GAMMA_EN - when defined, the duty is (lvl*lvl) >> LEVEL_W
//                        (square-law gamma). When undefined, the duty is
//                        linear in lvl and no multiplier is built.
//
// Parameters:
//   NSEG     number of segment lanes (7 segments plus DP)
//   LEVEL_W  brightness level width; PWM period is 2**LEVEL_W cycles
//   PRESC_W  decay prescaler width (minimum 4)
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   seg_in     raw active-high segment pattern, synchronous to clk
//   decay_sel  fade speed select; tick period is 2**(PRESC_W-3+decay_sel)
//   blank      forces all outputs off (levels keep evolving)
//   seg_out    registered, PWM-dimmed segment drive
module seg_fader #(
  parameter int NSEG    = 8,
  parameter int LEVEL_W = 4,
  parameter int PRESC_W = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSEG-1:0] seg_in,
  input  logic [1:0]      decay_sel,
  input  logic            blank,
  output logic [NSEG-1:0] seg_out
);

  localparam logic [LEVEL_W-1:0] LMAX = '1;
  // Wide enough to hold the largest tick exponent, PRESC_W itself.
  localparam int SH_W = $clog2(PRESC_W + 1);

  logic [LEVEL_W-1:0]            pwm_cnt;
  logic [PRESC_W-1:0]            presc;
  logic [SH_W-1:0]               tick_bits;
  logic [PRESC_W-1:0]            tick_mask;
  logic                          tick;
  logic [NSEG-1:0][LEVEL_W-1:0]  lvl;
  logic [NSEG-1:0][LEVEL_W-1:0]  duty;
  logic [NSEG-1:0]               seg_nxt;
`ifdef SEG_FADER_GAMMA_EN
  logic [2*LEVEL_W-1:0]          sq;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      presc   <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + LEVEL_W'(1);
      presc   <= presc + PRESC_W'(1);
    end
  end

  // Tick when the low (PRESC_W-3+decay_sel) prescaler bits are all ones.
  // At decay_sel=3 the shift reaches PRESC_W, the shifted value becomes
  // zero and the mask covers the whole prescaler.
  always_comb begin
    tick_bits = SH_W'(PRESC_W - 3) + SH_W'(decay_sel);
    tick_mask = ~({PRESC_W{1'b1}} << tick_bits);
    tick      = &(presc | ~tick_mask);
  end

  // Load beats decay; decay saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl <= '0;
    end else begin
      for (int i = 0; i < NSEG; i++) begin
        if (seg_in[i]) begin
          lvl[i] <= LMAX;
        end else if (tick && (lvl[i] != '0)) begin
          lvl[i] <= lvl[i] - LEVEL_W'(1);
        end
      end
    end
  end

  always_comb begin
    duty    = '0;
    seg_nxt = '0;
`ifdef SEG_FADER_GAMMA_EN
    sq      = '0;
`endif
    for (int i = 0; i < NSEG; i++) begin
`ifdef SEG_FADER_GAMMA_EN
      sq      = {{LEVEL_W{1'b0}}, lvl[i]} * {{LEVEL_W{1'b0}}, lvl[i]};
      duty[i] = LEVEL_W'(sq >> LEVEL_W);
`else
      duty[i] = lvl[i];
`endif
      // Full level bypasses the PWM so a lit segment has no gaps; without
      // the bypass duty 15 would still leave one dark cycle per period.
      if (blank) begin
        seg_nxt[i] = 1'b0;
      end else if (lvl[i] == LMAX) begin
        seg_nxt[i] = 1'b1;
      end else begin
        seg_nxt[i] = (pwm_cnt < duty[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out <= '0;
    end else begin
      seg_out <= seg_nxt;
    end
  end

endmodule
